reg_file_sb: RTL and testbench

- Parametrised, scoreboarded register file for the ACDC datapath; second generation of the core register file.
- Two combinational read ports and one general write port.
- Dedicated immediate-register (RIM) write port at a parameter-selected index.
- Optional write-to-read bypass and optional hardwired-zero register 0.
- Per-register busy scoreboard lets the control FSM stall on registers awaiting multi-cycle results (loads).

---
 rtl/acdc_rf_pkg.sv | 11 +
 rtl/rf_scoreboard.sv | 71 +++++++
 rtl/reg_file_sb.sv | 100 ++++++++++
 tb/tb_reg_file_sb.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/acdc_rf_pkg.sv
// Shared defaults and types for the ACDC scoreboarded register file.
package acdc_rf_pkg;

    localparam int RF_W       = 8;
    localparam int RF_D       = 4;
    localparam int RF_RIM_IDX = (1 << RF_D) - 1;

    typedef logic [RF_D-1:0] reg_addr_t;
    typedef logic [RF_W-1:0] reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: one pending-result bit per register plus a running
// population count. A claim always beats a clear on the same register,
// because the claim stands for a newer producer still in flight.
module rf_scoreboard
    import acdc_rf_pkg::*;
#(
    parameter int D       = RF_D,
    parameter int RIM_IDX = (1 << D) - 1,
    parameter int ZERO_R0 = 0
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         claim_en,
    input  logic [D-1:0] claim_addr,
    input  logic         clr_w_en,
    input  logic [D-1:0] clr_w_addr,
    input  logic         clr_i_en,
    input  logic [D-1:0] raddrA,
    input  logic [D-1:0] raddrB,
    output logic         busyA,
    output logic         busyB,
    output logic [D:0]   busy_cnt
);

    localparam int           N     = 1 << D;
    localparam logic [D-1:0] RIM_A = D'(RIM_IDX);

    logic [N-1:0] busy_q, busy_d;
    logic [D:0]   cnt_q, cnt_d;
    logic         claim_v;
    logic         set_inc, clr_w_dec, clr_i_dec;

    // Qualify the claim, then build the next busy vector (clears first, claim last so it wins).
    always_comb begin
        claim_v = claim_en && !((ZERO_R0 != 0) && (claim_addr == '0));
        busy_d  = busy_q;
        if (clr_w_en) busy_d[clr_w_addr] = 1'b0;
        if (clr_i_en) busy_d[RIM_A]      = 1'b0;
        if (claim_v)  busy_d[claim_addr] = 1'b1;
    end

    // Count only real transitions so busy_cnt tracks popcount(busy) without a full adder tree.
    always_comb begin
        set_inc   = claim_v && !busy_q[claim_addr];
        clr_w_dec = clr_w_en && busy_q[clr_w_addr]
                    && !(claim_v && (claim_addr == clr_w_addr));
        clr_i_dec = clr_i_en && busy_q[RIM_A]
                    && !(claim_v && (claim_addr == RIM_A))
                    && !(clr_w_en && (clr_w_addr == RIM_A));
        cnt_d     = cnt_q + (D+1)'(set_inc) - (D+1)'(clr_w_dec) - (D+1)'(clr_i_dec);
    end

    // Scoreboard state; a reset drops every pending claim at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Lookups use registered state only; a clear landing this edge is not forwarded.
    always_comb begin
        busyA    = busy_q[raddrA];
        busyB    = busy_q[raddrB];
        busy_cnt = cnt_q;
    end

endmodule

// File: rtl/reg_file_sb.sv
// Scoreboarded register file: two combinational read ports, one general
// write port, a dedicated immediate-register write port, optional
// write-to-read bypass and optional hardwired-zero r0.
module reg_file_sb
    import acdc_rf_pkg::*;
#(
    parameter int W       = RF_W,
    parameter int D       = RF_D,
    parameter int RIM_IDX = (1 << D) - 1,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         write_en,
    input  logic [D-1:0] waddr,
    input  logic [W-1:0] data_in,
    input  logic         imm_we,
    input  logic [W-1:0] imm_in,
    input  logic [D-1:0] raddrA,
    input  logic [D-1:0] raddrB,
    output logic [W-1:0] data_outA,
    output logic [W-1:0] data_outB,
    input  logic         claim_en,
    input  logic [D-1:0] claim_addr,
    output logic         busyA,
    output logic         busyB,
    output logic [D:0]   busy_cnt
);

    localparam int           N     = 1 << D;
    localparam logic [D-1:0] RIM_A = D'(RIM_IDX);

    generate
        if ((RIM_IDX < 0) || (RIM_IDX >= N)) begin : g_bad_rim_idx
            $error("reg_file_sb: RIM_IDX (%0d) must be below 2**D (%0d)", RIM_IDX, N);
        end
    endgenerate

    logic [W-1:0] regs_q [N];
    logic         gen_wr, imm_wr;

    // Resolve write priority: imm owns RIM, so a colliding general write is dropped;
    // r0 swallows writes when hardwired to zero.
    always_comb begin
        imm_wr = imm_we && !((ZERO_R0 != 0) && (RIM_A == '0));
        gen_wr = write_en
                 && !(imm_we && (waddr == RIM_A))
                 && !((ZERO_R0 != 0) && (waddr == '0));
    end

    // Register storage.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N; i++) regs_q[i] <= '0;
        end else begin
            if (gen_wr) regs_q[waddr] <= data_in;
            if (imm_wr) regs_q[RIM_A] <= imm_in;
        end
    end

    // One read port: stored value, optionally overridden by same-cycle write data
    // (imm checked last so it wins, mirroring the write priority), then zero-forced.
    function automatic logic [W-1:0] read_mux(input logic [D-1:0] ra);
        logic [W-1:0] v;
        v = regs_q[ra];
        if (BYPASS != 0) begin
            if (write_en && (ra == waddr)) v = data_in;
            if (imm_we && (ra == RIM_A))   v = imm_in;
        end
        if ((ZERO_R0 != 0) && (ra == '0)) v = '0;
        return v;
    endfunction

    // Combinational read ports.
    always_comb begin
        data_outA = read_mux(raddrA);
        data_outB = read_mux(raddrB);
    end

    rf_scoreboard #(
        .D       (D),
        .RIM_IDX (RIM_IDX),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .clr_w_en   (gen_wr),
        .clr_w_addr (waddr),
        .clr_i_en   (imm_wr),
        .raddrA     (raddrA),
        .raddrB     (raddrB),
        .busyA      (busyA),
        .busyB      (busyB),
        .busy_cnt   (busy_cnt)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: three instances (bypass, no bypass,
// zero-r0) share one stimulus stream.
module tb_reg_file_sb;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       write_en, imm_we, claim_en;
    logic [3:0] waddr, raddrA, raddrB, claim_addr;
    logic [7:0] data_in, imm_in;

    logic [7:0] a1, b1, a0, b0, az, bz;
    logic       ba1, bb1, ba0, bb0, baz, bbz;
    logic [4:0] c1, c0, cz;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    reg_file_sb #(.W(8), .D(4), .RIM_IDX(15), .BYPASS(1), .ZERO_R0(0)) dut (
        .CLK(CLK), .RST_N(RST_N), .write_en(write_en), .waddr(waddr), .data_in(data_in),
        .imm_we(imm_we), .imm_in(imm_in), .raddrA(raddrA), .raddrB(raddrB),
        .data_outA(a1), .data_outB(b1), .claim_en(claim_en), .claim_addr(claim_addr),
        .busyA(ba1), .busyB(bb1), .busy_cnt(c1));

    reg_file_sb #(.W(8), .D(4), .RIM_IDX(15), .BYPASS(0), .ZERO_R0(0)) dut_nb (
        .CLK(CLK), .RST_N(RST_N), .write_en(write_en), .waddr(waddr), .data_in(data_in),
        .imm_we(imm_we), .imm_in(imm_in), .raddrA(raddrA), .raddrB(raddrB),
        .data_outA(a0), .data_outB(b0), .claim_en(claim_en), .claim_addr(claim_addr),
        .busyA(ba0), .busyB(bb0), .busy_cnt(c0));

    reg_file_sb #(.W(8), .D(4), .RIM_IDX(15), .BYPASS(1), .ZERO_R0(1)) dut_z (
        .CLK(CLK), .RST_N(RST_N), .write_en(write_en), .waddr(waddr), .data_in(data_in),
        .imm_we(imm_we), .imm_in(imm_in), .raddrA(raddrA), .raddrB(raddrB),
        .data_outA(az), .data_outB(bz), .claim_en(claim_en), .claim_addr(claim_addr),
        .busyA(baz), .busyB(bbz), .busy_cnt(cz));

    typedef struct {
        logic       we;   logic [3:0] wa; logic [7:0] d;
        logic       iwe;  logic [7:0] ii;
        logic [3:0] ra;   logic [3:0] rb;
        logic       cen;  logic [3:0] ca;
        logic [7:0] ea;   logic [7:0] eb; logic [7:0] ea_nb;
        logic       eba;  logic       ebb; logic [4:0] ecnt;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        write_en = 1'b0; imm_we = 1'b0; claim_en = 1'b0;
        waddr = '0; data_in = '0; imm_in = '0; claim_addr = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [7:0] d,
                                input logic iwe, input logic [7:0] ii,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic cen, input logic [3:0] ca,
                                input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ea_nb,
                                input logic eba, input logic ebb, input logic [4:0] ecnt);
        vec_t v;
        v.we = we; v.wa = wa; v.d = d; v.iwe = iwe; v.ii = ii; v.ra = ra; v.rb = rb;
        v.cen = cen; v.ca = ca; v.ea = ea; v.eb = eb; v.ea_nb = ea_nb;
        v.eba = eba; v.ebb = ebb; v.ecnt = ecnt;
        return v;
    endfunction

    initial begin
        //              we wa  d      iwe ii     ra  rb  cen ca  ea     eb     ea_nb  bA bB cnt
        vecs[0]  = mk(1, 5,  8'hC3, 0, 8'h00, 5,  0,  0, 0,  8'hC3, 8'h00, 8'h00, 0, 0, 0);
        vecs[1]  = mk(0, 0,  8'h00, 0, 8'h00, 5,  3,  0, 0,  8'hC3, 8'h00, 8'hC3, 0, 0, 0);
        vecs[2]  = mk(1, 15, 8'h11, 1, 8'h22, 15, 5,  0, 0,  8'h22, 8'hC3, 8'h00, 0, 0, 0);
        vecs[3]  = mk(0, 0,  8'h00, 0, 8'h00, 15, 5,  0, 0,  8'h22, 8'hC3, 8'h22, 0, 0, 0);
        vecs[4]  = mk(0, 0,  8'h00, 1, 8'h7F, 5,  15, 0, 0,  8'hC3, 8'h7F, 8'hC3, 0, 0, 0);
        vecs[5]  = mk(0, 0,  8'h00, 0, 8'h00, 15, 15, 0, 0,  8'h7F, 8'h7F, 8'h7F, 0, 0, 0);
        vecs[6]  = mk(0, 0,  8'h00, 0, 8'h00, 2,  7,  1, 2,  8'h00, 8'h00, 8'h00, 0, 0, 0);
        vecs[7]  = mk(0, 0,  8'h00, 0, 8'h00, 2,  7,  1, 7,  8'h00, 8'h00, 8'h00, 1, 0, 1);
        vecs[8]  = mk(1, 2,  8'h44, 0, 8'h00, 2,  7,  0, 0,  8'h44, 8'h00, 8'h00, 1, 1, 2);
        vecs[9]  = mk(1, 7,  8'h55, 0, 8'h00, 7,  2,  1, 7,  8'h55, 8'h44, 8'h00, 1, 0, 1);
        vecs[10] = mk(0, 0,  8'h00, 0, 8'h00, 7,  2,  0, 0,  8'h55, 8'h44, 8'h55, 1, 0, 1);
        vecs[11] = mk(1, 7,  8'h66, 0, 8'h00, 7,  2,  0, 0,  8'h66, 8'h44, 8'h55, 1, 0, 1);
        vecs[12] = mk(0, 0,  8'h00, 0, 8'h00, 7,  2,  0, 0,  8'h66, 8'h44, 8'h66, 0, 0, 0);
        vecs[13] = mk(0, 0,  8'h00, 0, 8'h00, 1,  15, 1, 1,  8'h00, 8'h7F, 8'h00, 0, 0, 0);
        vecs[14] = mk(0, 0,  8'h00, 0, 8'h00, 1,  15, 1, 15, 8'h00, 8'h7F, 8'h00, 1, 0, 1);
        vecs[15] = mk(1, 1,  8'hA1, 1, 8'hB2, 1,  15, 0, 0,  8'hA1, 8'hB2, 8'h00, 1, 1, 2);
        vecs[16] = mk(0, 0,  8'h00, 0, 8'h00, 1,  15, 0, 0,  8'hA1, 8'hB2, 8'hA1, 0, 0, 0);

        // Reset state
        RST_N = 1'b0;
        idle();
        raddrA = 4'd3; raddrB = 4'd15;
        #3;
        chk("rst_dataA", a1, 8'h00);
        chk("rst_dataB", b1, 8'h00);
        chk("rst_busyA", ba1, 1'b0);
        chk("rst_busyB", bb1, 1'b0);
        chk("rst_cnt",   c1, 5'd0);
        chk("rst_cnt_z", cz, 5'd0);
        #9 RST_N = 1'b1;
        tick();

        // Table: combinational outputs checked before each edge
        for (int i = 0; i < NV; i++) begin
            write_en = vecs[i].we;  waddr = vecs[i].wa; data_in = vecs[i].d;
            imm_we = vecs[i].iwe;   imm_in = vecs[i].ii;
            raddrA = vecs[i].ra;    raddrB = vecs[i].rb;
            claim_en = vecs[i].cen; claim_addr = vecs[i].ca;
            #2;
            chk($sformatf("v%0d_dataA", i),    a1,  vecs[i].ea);
            chk($sformatf("v%0d_dataB", i),    b1,  vecs[i].eb);
            chk($sformatf("v%0d_dataA_nb", i), a0,  vecs[i].ea_nb);
            chk($sformatf("v%0d_busyA", i),    ba1, vecs[i].eba);
            chk($sformatf("v%0d_busyB", i),    bb1, vecs[i].ebb);
            chk($sformatf("v%0d_cnt", i),      c1,  vecs[i].ecnt);
            tick();
        end

        // Full scoreboard: claim every register on consecutive edges
        idle();
        for (int r = 0; r < 16; r++) begin
            claim_en = 1'b1; claim_addr = 4'(r);
            tick();
        end
        idle();
        #1;
        chk("full_cnt",    c1, 5'b10000);
        chk("full_cnt_nb", c0, 5'b10000);
        chk("full_cnt_z",  cz, 5'd15);

        // Write and claim r9 together: still busy, count unchanged, data lands
        write_en = 1'b1; waddr = 4'd9; data_in = 8'h99;
        claim_en = 1'b1; claim_addr = 4'd9;
        raddrA = 4'd9; raddrB = 4'd0;
        tick();
        idle();
        #1;
        chk("r9_cnt",   c1, 5'b10000);
        chk("r9_busyA", ba1, 1'b1);
        chk("r9_dataA", a1, 8'h99);

        // Zero register: write 0xFF to r0 and claim r0
        write_en = 1'b1; waddr = 4'd0; data_in = 8'hFF;
        claim_en = 1'b1; claim_addr = 4'd0;
        raddrA = 4'd0;
        #1;
        chk("z_pre_dataA",  az, 8'h00);
        chk("z_pre_bypass", a1, 8'hFF);
        tick();
        idle();
        #1;
        chk("z_dataA", az,  8'h00);
        chk("z_busyA", baz, 1'b0);
        chk("z_cnt",   cz,  5'd15);
        chk("r0_claim_busy_cnt", c1, 5'b10000);
        chk("r0_dataA", a1, 8'hFF);

        // Plain write to busy r0 clears it on the normal instance only
        write_en = 1'b1; waddr = 4'd0; data_in = 8'hFF;
        tick();
        idle();
        #1;
        chk("r0_clear_cnt",  c1, 5'd15);
        chk("r0_clear_busy", ba1, 1'b0);
        chk("z_cnt_after",   cz, 5'd15);

        // Reset mid-stream
        write_en = 1'b1; waddr = 4'd3; data_in = 8'h5A;
        claim_en = 1'b1; claim_addr = 4'd4;
        tick();
        idle();
        raddrA = 4'd3; raddrB = 4'd4;
        #1;
        chk("pre_rst_dataA", a1, 8'h5A);
        chk("pre_rst_busyB", bb1, 1'b1);
        #1 RST_N = 1'b0;
        #1;
        chk("midrst_dataA", a1, 8'h00);
        chk("midrst_cnt",   c1, 5'd0);
        chk("midrst_busyB", bb1, 1'b0);
        chk("midrst_cnt_z", cz, 5'd0);

        // A write held across an edge during reset must not land
        write_en = 1'b1; waddr = 4'd3; data_in = 8'h77;
        claim_en = 1'b1; claim_addr = 4'd3;
        raddrA = 4'd6;
        tick();
        RST_N = 1'b1;
        idle();
        raddrA = 4'd3;
        #1;
        chk("rst_edge_dataA", a1, 8'h00);
        chk("rst_edge_busyA", ba1, 1'b0);
        chk("rst_edge_cnt",   c1, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
